// File: rtl/iic_event_log_pkg.sv
// rtl/iic_event_log_pkg.sv - register offsets, STATUS bit indices and access FSM states
package iic_event_log_pkg;

  localparam logic [11:0] OFF_COUNT      = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h001;
  localparam logic [11:0] OFF_CLEAR      = 12'h002;
  localparam logic [11:0] OFF_FREEZE     = 12'h003;
  localparam logic [11:0] OFF_DROPPED    = 12'h004;
  localparam logic [11:0] OFF_ENTRY_BASE = 12'h100;

  localparam int STATUS_OVERFLOW = 0;
  localparam int STATUS_EMPTY    = 1;
  localparam int STATUS_FROZEN   = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ACK    = 2'd2
  } acc_state_e;

endpackage

// File: rtl/iic_event_log_ram.sv
// rtl/iic_event_log_ram.sv - DEPTHx8 simple dual-port RAM, registered read, contents not reset
module event_log_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iWrEn,
  input  logic [AW-1:0] ivWrAddr,
  input  logic [7:0]    ivWrData,
  input  logic [AW-1:0] ivRdAddr,
  output logic [7:0]    ovRdData
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[ivRdAddr];
  end

  always_ff @(posedge iClk) begin
    if (iWrEn) begin
      mem[ivWrAddr] <= ivWrData;
    end
    rd_data_q <= rd_data_d;
  end

  assign ovRdData = rd_data_q;

endmodule

// File: rtl/iic_event_log.sv
// rtl/iic_event_log.sv - block-2 event log: circular capture buffer, control registers, access FSM
module iic_event_log
  import iic_event_log_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [12:0] ivRegID,
  input  logic        iRnW,
  input  logic        iBlockEnable,
  input  logic [7:0]  ivWrData,
  input  logic        iEventValid,
  input  logic [7:0]  ivEventCode,
  output logic [7:0]  ovRdData,
  output logic        oAccessDone,
  output logic        oOverflow,
  output logic [7:0]  ovCount
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  acc_state_e    state_q, state_d;
  logic [11:0]   acc_off_q, acc_off_d;
  logic          acc_rnw_q, acc_rnw_d;
  logic          acc_wbit_q, acc_wbit_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          freeze_q, freeze_d;
  logic [7:0]    dropped_q, dropped_d;
  logic [7:0]    reg_val_q, reg_val_d;
  logic          is_entry_q, is_entry_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic          do_write;
  logic          clear_wr;
  logic          freeze_wr;
  logic          ram_we;
  logic [11:0]   offset;
  logic [11:0]   entry_n;
  logic [AW-1:0] ram_rd_addr;
  logic [7:0]    ram_rd_data;
  logic [7:0]    status;
  logic          unused_bits;

  assign unused_bits = ^{ivRegID[12], ivWrData[7:1]};

  // Access FSM; offset, direction and the FREEZE bit are latched on the enable pulse
  always_comb begin
    state_d    = state_q;
    acc_off_d  = acc_off_q;
    acc_rnw_d  = acc_rnw_q;
    acc_wbit_d = acc_wbit_q;
    do_write   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iBlockEnable) begin
          state_d    = S_LOOKUP;
          acc_off_d  = ivRegID[11:0];
          acc_rnw_d  = iRnW;
          acc_wbit_d = ivWrData[0];
        end
      end
      S_LOOKUP: begin
        state_d  = S_ACK;
        do_write = ~acc_rnw_q;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign clear_wr  = do_write && (acc_off_q == OFF_CLEAR);
  assign freeze_wr = do_write && (acc_off_q == OFF_FREEZE);

  // Capture path; a CLEAR in the same cycle swallows the event without counting it
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    freeze_d   = freeze_q;
    ram_we     = 1'b0;
    if (clear_wr) begin
      wr_ptr_d   = '0;
      count_d    = 8'd0;
      overflow_d = 1'b0;
      dropped_d  = 8'd0;
    end else if (iEventValid) begin
      if (freeze_q) begin
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q == DEPTH_B) overflow_d = 1'b1;
        else                    count_d    = count_q + 8'd1;
      end
    end
    if (freeze_wr) freeze_d = acc_wbit_q;
  end

  // Read path stage 1: RAM address and register mux from the live register ID
  always_comb begin
    offset      = ivRegID[11:0];
    entry_n     = offset - OFF_ENTRY_BASE;
    ram_rd_addr = wr_ptr_q - count_q[AW-1:0] + entry_n[AW-1:0];
    is_entry_d  = (offset >= OFF_ENTRY_BASE) && (entry_n < {4'b0000, count_q});
    status                  = 8'd0;
    status[STATUS_OVERFLOW] = overflow_q;
    status[STATUS_EMPTY]    = (count_q == 8'd0);
    status[STATUS_FROZEN]   = freeze_q;
    case (offset)
      OFF_COUNT:   reg_val_d = count_q;
      OFF_STATUS:  reg_val_d = status;
      OFF_FREEZE:  reg_val_d = {7'd0, freeze_q};
      OFF_DROPPED: reg_val_d = dropped_q;
      default:     reg_val_d = 8'd0;
    endcase
    rd_data_d = is_entry_q ? ram_rd_data : reg_val_q;
  end

  event_log_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .iClk     (iClk),
    .iWrEn    (ram_we),
    .ivWrAddr (wr_ptr_q),
    .ivWrData (ivEventCode),
    .ivRdAddr (ram_rd_addr),
    .ovRdData (ram_rd_data)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      acc_off_q  <= 12'd0;
      acc_rnw_q  <= 1'b0;
      acc_wbit_q <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= 8'd0;
      overflow_q <= 1'b0;
      freeze_q   <= 1'b0;
      dropped_q  <= 8'd0;
      reg_val_q  <= 8'd0;
      is_entry_q <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      acc_off_q  <= acc_off_d;
      acc_rnw_q  <= acc_rnw_d;
      acc_wbit_q <= acc_wbit_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      freeze_q   <= freeze_d;
      dropped_q  <= dropped_d;
      reg_val_q  <= reg_val_d;
      is_entry_q <= is_entry_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ovRdData    = rd_data_q;
  assign oAccessDone = (state_q == S_ACK);
  assign oOverflow   = overflow_q;
  assign ovCount     = count_q;

endmodule
